// File: rtl/sha256_msg_ctrl.sv
// Message sequencer for the sha256 core: packs a byte stream into 512-bit blocks, pads,
// chains state across blocks and hands out the digest. Define SHA256_CTRL_SHA224_EN for SHA-224.
module sha256_msg_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
`ifdef SHA256_CTRL_SHA224_EN
  input  logic         sha224,
`endif
  output logic         in_ready,
  output logic         core_start,
  output logic [0:511] core_block,
  output logic [0:255] core_hin,
  input  logic         core_done,
  input  logic [0:255] core_hout,
  output logic [0:255] digest,
  output logic         digest_valid,
  input  logic         digest_ack,
  output logic         busy
);

  localparam logic [0:255] Iv256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {StIdle, StFill, StPad, StLen, StHash, StDone} state_e;

  state_e           state_q, state_d;
  logic [5:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:255]     h_q, h_d;
  logic [0:511]     block_q, block_d;
  logic             start_q, start_d;
  logic [0:255]     digest_q, digest_d;
  logic             dvalid_q, dvalid_d;
  logic             final_q, final_d;
  logic             pad_pend_q, pad_pend_d;
  logic             mark_q, mark_d;

  logic             xfer;
  logic             end_marker;
  logic [8:0]       bidx;
  logic [63:0]      len_bits;
  logic [0:255]     iv_new;
  logic [0:255]     iv_done;
  logic [0:255]     hout_dig;

`ifdef SHA256_CTRL_SHA224_EN
  localparam logic [0:255] Iv224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  // Mode of the message in flight; resampled only when leaving IDLE.
  logic mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (state_q == StIdle && xfer) begin
      mode_q <= sha224;
    end
  end

  assign iv_new   = sha224 ? Iv224 : Iv256;
  assign iv_done  = mode_q ? Iv224 : Iv256;
  assign hout_dig = mode_q ? {core_hout[0:223], 32'h0} : core_hout;
`else
  assign iv_new   = Iv256;
  assign iv_done  = Iv256;
  assign hout_dig = core_hout;
`endif

  assign in_ready   = ~reset & ((state_q == StIdle) | (state_q == StFill));
  assign xfer       = in_valid & in_ready;
  assign end_marker = in_last & in_empty;
  assign bidx       = {ptr_q, 3'b000};
  assign len_bits   = 64'({count_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    h_d        = h_q;
    block_d    = block_q;
    start_d    = 1'b0;
    digest_d   = digest_q;
    dvalid_d   = dvalid_q;
    final_d    = final_q;
    pad_pend_d = pad_pend_q;
    mark_d     = mark_q;

    unique case (state_q)
      StIdle, StFill: begin
        if (xfer) begin
          if (state_q == StIdle) begin
            h_d        = iv_new;
            final_d    = 1'b0;
            pad_pend_d = 1'b0;
            mark_d     = 1'b0;
          end
          if (end_marker) begin
            state_d = StPad;
          end else begin
            block_d[bidx +: 8] = in_data;
            ptr_d              = ptr_q + 6'd1;
            count_d            = count_q + CNT_W'(1);
            if (ptr_q == 6'd63) begin
              state_d    = StHash;
              start_d    = 1'b1;
              final_d    = 1'b0;
              pad_pend_d = in_last;
            end else if (in_last) begin
              state_d = StPad;
            end else begin
              state_d = StFill;
            end
          end
        end
      end

      StPad: begin
        block_d[bidx +: 8] = mark_q ? 8'h00 : 8'h80;
        mark_d             = 1'b1;
        ptr_d              = ptr_q + 6'd1;
        if (ptr_q == 6'd55) begin
          state_d = StLen;
        end else if (ptr_q == 6'd63) begin
          // No room for the length field: finish this block and pad a fresh one.
          state_d    = StHash;
          start_d    = 1'b1;
          final_d    = 1'b0;
          pad_pend_d = 1'b1;
        end
      end

      StLen: begin
        block_d[448 +: 64] = len_bits;
        state_d            = StHash;
        start_d            = 1'b1;
        final_d            = 1'b1;
      end

      StHash: begin
        if (core_done) begin
          h_d   = core_hout;
          ptr_d = 6'd0;
          if (final_q) begin
            digest_d = hout_dig;
            dvalid_d = 1'b1;
            state_d  = StDone;
          end else if (pad_pend_q) begin
            pad_pend_d = 1'b0;
            state_d    = StPad;
          end else begin
            state_d = StFill;
          end
        end
      end

      StDone: begin
        if (digest_ack) begin
          state_d  = StIdle;
          dvalid_d = 1'b0;
          h_d      = iv_done;
          count_d  = '0;
          mark_d   = 1'b0;
          ptr_d    = 6'd0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= 6'd0;
      count_q    <= '0;
      h_q        <= Iv256;
      block_q    <= '0;
      start_q    <= 1'b0;
      digest_q   <= '0;
      dvalid_q   <= 1'b0;
      final_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      mark_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      h_q        <= h_d;
      block_q    <= block_d;
      start_q    <= start_d;
      digest_q   <= digest_d;
      dvalid_q   <= dvalid_d;
      final_q    <= final_d;
      pad_pend_q <= pad_pend_d;
      mark_q     <= mark_d;
    end
  end

  assign core_start   = start_q;
  assign core_block   = block_q;
  assign core_hin     = h_q;
  assign digest       = digest_q;
  assign digest_valid = dvalid_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: doc/sha256_msg_ctrl.md
Name: sha256_msg_ctrl

Overview:
- Message sequencer for the `sha256` compression core.
- Accepts a byte stream (e.g. from `uart_rx`) and packs it big-endian into 512-bit blocks.
- Applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit-length), issues one core job per block, and chains the 256-bit state across blocks.
- Presents the final digest with a valid/ack handshake. Sits between the byte source and the core in `top`.

Parameters:
- CNT_W, 32: width of the message byte counter (1..61). Message length is counted modulo 2^CNT_W bytes.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  message byte.
- in_valid  in  1  in_data (or an end marker) is offered.
- in_last  in  1  qualifies in_valid: final transfer of the message.
- in_empty  in  1  qualifies in_valid&in_last: transfer carries no byte (end marker only; allows the empty message).
- in_ready  out  1  controller accepts a transfer this cycle.
- core_start  out  1  one-cycle pulse launching a compression.
- core_block  out  [0:511]  block buffer; byte j is at bits [j*8 +: 8]. Stable from core_start until core_done.
- core_hin  out  [0:255]  chaining state input to the core.
- core_done  in  1  one-cycle pulse; core_hout is valid (feed-forward already added).
- core_hout  in  [0:255]  updated state from the core.
- digest  out  [0:255]  final hash.
- digest_valid  out  1  digest is present.
- digest_ack  in  1  consumer has taken the digest.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, ptr=0, count=0, H=SHA-256 IV (6a09e667 … 5be0cd19), core_start=0, core_block=0, digest=0, digest_valid=0, in_ready=0 while reset is high.
- core_hin = H at all times.
- A transfer happens when in_valid & in_ready.
- in_ready=1 only in IDLE and FILL.
- States:
  - IDLE: a transfer goes to FILL. A byte transfer is written at ptr=0. An empty end marker goes directly to PAD with count=0.
  - FILL: each byte transfer writes core_block byte[ptr], then ptr++ and count++ (both wrap).
    - If ptr was 63 → HASH, with final=0 and pad_pend=in_last.
    - Else if in_last → PAD.
    - An empty end marker in FILL → PAD without writing.
  - PAD: one byte per cycle.
    - First cycle writes 0x80 at ptr and sets mark=1.
    - Subsequent cycles write 0x00.
    - ptr increments each cycle.
    - When ptr==56 after the mark is written → LEN.
    - If ptr wraps 63→0 before reaching 56 → HASH with final=0 and pad_pend=1.
  - LEN: one cycle. Bytes 56..63 = {count,3'b0} zero-extended to 64 bits, big-endian. Then → HASH with final=1.
  - HASH: core_start=1 in the first cycle only, then wait. On core_done, H<=core_hout and ptr<=0.
    - If final=1: digest<=core_hout, digest_valid<=1 → DONE.
    - Else if pad_pend=1 → PAD (the mark is written if not already).
    - Else → FILL.
    - core_done in any other state is ignored.
  - DONE: digest_valid held. On digest_ack → IDLE, digest_valid=0, H=IV, count=0, mark=0, ptr=0. digest keeps its value.
- Block count: 1 block for n mod 64 ≤ 55, else 2 blocks for the tail.
- Latency: digest_valid rises the cycle after the final core_done.
- Bytes are never dropped: in_ready is low in PAD/LEN/HASH/DONE.
- Reset mid-operation returns to the reset state. A later core_done is ignored.
- count wraps at 2^CNT_W; the length field uses the wrapped value.

Optional Feature:
- Macro SHA256_CTRL_SHA224_EN.
- When defined:
  - Adds input port `sha224` (1 bit), sampled on the IDLE-exit transfer.
  - If sha224=1: IV = c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4, and digest bits [224:255] are forced to 0.
  - The reload in DONE uses the mode of the completed message's IV. The next IDLE exit resamples sha224.
- When undefined: no port, SHA-256 only, identical logic otherwise.

Test Plan:
- Bench uses a behavioural core model with a random 1-20 cycle core_done delay.
- Empty message (single in_empty end marker) → digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, exactly 1 core_start.
- "abc" (last on 'c') → ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad. Block bytes 3=0x80, 63=0x18.
- 56-byte "abcdbcdecdefdefg…nopq" → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 2 core_starts. 55 × 'a' → 1 core_start. 64 × 'a' → 2 core_starts, second block starting with 0x80.
- Reset asserted mid-HASH of a 2-block message → all outputs return to reset values. A following "abc" still yields the correct digest.
- digest_ack withheld 100 cycles → digest_valid stays 1, in_ready stays 0, in_valid ignored. Ack → IDLE next cycle.
- With SHA256_CTRL_SHA224_EN and sha224=1, "abc" → 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, low 32 bits 0. Then sha224=0 "abc" → the SHA-256 value.
